// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg
// Shared definitions for the memory-stage bus bridge: the controller state
// encoding, the bus command values carried on bus_we, the default value
// returned for loads that never received bus data, and a small alignment
// helper used when an access first shows up.
package mem_bus_pkg;

   // Controller states; the encoding is fixed so the state can be decoded by
   // other blocks or debug logic without going through the enum.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } bridge_state_t;

   // Values driven on bus_we.
   localparam logic BUS_CMD_READ  = 1'b0;
   localparam logic BUS_CMD_WRITE = 1'b1;

   // Load data handed back when a load times out or is rejected as misaligned.
   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0000_0000;

   // A word access is legal only when the two byte-offset bits are zero.
   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/mem_stage_bridge_wait_counter.sv
// wait_counter
// Counts bus wait cycles for the bridge. The count is cleared whenever the
// bridge is not waiting on the bus and advances once per cycle in which a
// request is outstanding without an acknowledge. The terminal-count flag is
// raised while the count sits one below TERMINAL, so the cycle that would
// bring the count to TERMINAL is recognised in the same cycle it happens.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset
//   clear  - synchronous clear, wins over enable
//   enable - advance the count by one
//   tc     - the next enabled cycle reaches TERMINAL
module wait_counter #(
   parameter int unsigned TERMINAL = 16,
   parameter int unsigned WIDTH    = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam logic [WIDTH-1:0] TC_VALUE = WIDTH'(TERMINAL - 1);

   logic [WIDTH-1:0] count;

   // Wait-cycle count; clear has priority so a fresh request always starts
   // counting from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + WIDTH'(1);
      end
   end

   // Terminal flag looks one cycle ahead of the stored count.
   assign tc = (count == TC_VALUE);

endmodule

// File: rtl/mem_stage_bridge.sv
// mem_stage_bridge
// Sits between the CPU memory stage and a request/acknowledge data bus. Each
// aligned load or store becomes one bus transaction while the pipeline is
// held with stall; misaligned accesses are rejected in the same cycle without
// touching the bus. A bus that never acknowledges is abandoned after TIMEOUT
// request cycles and flagged on the sticky buserr output.
//
// Ports:
//   clk, reset      - system clock and asynchronous active-high reset
//   memread         - CPU load in memory stage
//   memwrite        - CPU store in memory stage (wins over memread)
//   memaddr         - byte address
//   memwritedata    - store data
//   memreaddata     - load data towards the MEM/WB register
//   stall           - holds PC and pipeline registers while high
//   bus_req         - bus transaction request
//   bus_we          - bus direction, 1 = write
//   bus_addr        - word-aligned bus address
//   bus_wdata       - bus write data
//   bus_ack         - bus transaction complete, bus_rdata valid
//   bus_rdata       - bus read data
//   buserr          - sticky flag: a transaction timed out
//   misalign        - one-cycle pulse for an access with memaddr[1:0] != 0
module mem_stage_bridge
   import mem_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT   = 16,
   parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [31:0] memaddr,
   input  logic [31:0] memwritedata,
   output logic [31:0] memreaddata,
   output logic        stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        buserr,
   output logic        misalign
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   bridge_state_t state;
   bridge_state_t next_state;

   logic        access;
   logic        aligned;
   logic        start_access;
   logic        reject_access;
   logic        ack_seen;
   logic        timed_out;
   logic        cnt_tc;
   logic        cnt_clear;
   logic        cnt_enable;
   logic [31:0] rdata_q;
   logic        buserr_q;

   assign access        = memread | memwrite;
   assign aligned       = is_word_aligned(memaddr);
   assign start_access  = (state == IDLE) && access && aligned;
   assign reject_access = (state == IDLE) && access && !aligned;
   assign ack_seen      = (state == REQ) && bus_ack;
   assign timed_out     = (state == REQ) && !bus_ack && cnt_tc;

   // The counter only runs while a request is outstanding and unanswered.
   assign cnt_clear  = (state != REQ);
   assign cnt_enable = (state == REQ) && !bus_ack;

   wait_counter #(
      .TERMINAL (TIMEOUT),
      .WIDTH    (CNT_W)
   ) u_wait_counter (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (cnt_enable),
      .tc     (cnt_tc)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. DONE always falls back to IDLE: the access the CPU is
   // still presenting in DONE is the one just completed, so it must not be
   // picked up again.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start_access) begin
               next_state = REQ;
            end
         end
         REQ: begin
            if (ack_seen || timed_out) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Bus command registers are captured once when the access is accepted and
   // then held steady for the whole request, so the bus sees stable address,
   // data and direction regardless of what the pipeline does meanwhile.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus_we    <= BUS_CMD_READ;
         bus_addr  <= '0;
         bus_wdata <= '0;
      end else if (start_access) begin
         bus_we    <= memwrite ? BUS_CMD_WRITE : BUS_CMD_READ;
         bus_addr  <= memaddr;
         bus_wdata <= memwritedata;
      end
   end

   // Returned load data and the sticky error flag. Stores leave the held read
   // data alone; a timeout replaces it with the error value whatever the
   // direction, and the error flag stays set until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q  <= '0;
         buserr_q <= 1'b0;
      end else if (timed_out) begin
         rdata_q  <= ERR_RDATA;
         buserr_q <= 1'b1;
      end else if (ack_seen && (bus_we == BUS_CMD_READ)) begin
         rdata_q  <= bus_rdata;
      end
   end

   // Combinational outputs. stall has to rise in the very cycle the access
   // appears, so it cannot wait for a registered state. The combinational
   // terms are masked by reset so that everything reads as idle while reset
   // is held, even if the CPU is still presenting an access.
   always_comb begin
      bus_req     = (state == REQ);
      stall       = !reset && (start_access || (state == REQ));
      misalign    = !reset && reject_access;
      memreaddata = misalign ? ERR_RDATA : rdata_q;
      buserr      = buserr_q;
   end

endmodule

// File: tb/tb_mem_stage_bridge.sv
// tb_mem_stage_bridge
// Self-checking bench for mem_stage_bridge. The bench plays the CPU and a bus
// slave with a chosen acknowledge latency. For every access the expected
// stall length, request length, returned data and status flags come from a
// transaction-level model: a latency below TIMEOUT yields latency+1 request
// cycles, anything else is a timeout of TIMEOUT request cycles, and stall
// covers the request cycles plus the cycle the access first appears.
module tb_mem_stage_bridge;
   import mem_bus_pkg::*;

   localparam int unsigned TIMEOUT   = 4;
   localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        memread;
   logic        memwrite;
   logic [31:0] memaddr;
   logic [31:0] memwritedata;
   logic [31:0] memreaddata;
   logic        stall;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        buserr;
   logic        misalign;

   int checks = 0;
   int errors = 0;

   // Reference model state: the last data a load handed back, and whether
   // any access has timed out since the last reset.
   logic [31:0] model_rdata  = 32'h0;
   logic        model_buserr = 1'b0;

   mem_stage_bridge #(
      .TIMEOUT   (TIMEOUT),
      .ERR_RDATA (ERR_RDATA)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .memread      (memread),
      .memwrite     (memwrite),
      .memaddr      (memaddr),
      .memwritedata (memwritedata),
      .memreaddata  (memreaddata),
      .stall        (stall),
      .bus_req      (bus_req),
      .bus_we       (bus_we),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_ack      (bus_ack),
      .bus_rdata    (bus_rdata),
      .buserr       (buserr),
      .misalign     (misalign)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Hard stop in case something upstream ever stops advancing.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Presents one CPU access and plays the bus slave. latency is the number of
   // request cycles without ack before ack is given; a latency of TIMEOUT or
   // more means the slave never answers. Inputs change on the falling edge and
   // outputs are sampled 1 time unit later, well before the next rising edge.
   task automatic applyStimulus(input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int latency, input logic [31:0] rdata);
      logic aligned;
      logic timeout;
      int   exp_req;
      int   stall_cnt;
      int   req_cnt;
      logic done;

      aligned   = (addr[1:0] == 2'b00);
      timeout   = (latency >= int'(TIMEOUT));
      exp_req   = timeout ? int'(TIMEOUT) : latency + 1;
      stall_cnt = 0;
      req_cnt   = 0;
      done      = 1'b0;

      @(negedge clk);
      memread      = rd;
      memwrite     = wr;
      memaddr      = addr;
      memwritedata = wdata;
      bus_ack      = 1'b0;

      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         #1;
         if (stall) stall_cnt++;
         if (bus_req) begin
            req_cnt++;
            checkOutput("bus_we", 32'(bus_we), 32'(wr));
            checkOutput("bus_addr", bus_addr, addr);
            if (wr) checkOutput("bus_wdata", bus_wdata, wdata);
            if (req_cnt - 1 == latency) begin
               bus_ack   = 1'b1;
               bus_rdata = rdata;
            end
         end
         if (!stall) begin
            done = 1'b1;
         end else begin
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
         end
      end

      if (!done) begin
         checkOutput("cycle_budget", 32'd0, 32'd1);
      end else if (aligned) begin
         if (timeout) model_rdata = ERR_RDATA;
         else if (!wr) model_rdata = rdata;
         model_buserr = model_buserr | timeout;
         checkOutput("stall_cycles", 32'(stall_cnt), 32'(exp_req + 1));
         checkOutput("req_cycles", 32'(req_cnt), 32'(exp_req));
         checkOutput("memreaddata", memreaddata, model_rdata);
         checkOutput("misalign", 32'(misalign), 32'd0);
         checkOutput("buserr", 32'(buserr), 32'(model_buserr));
      end else begin
         checkOutput("stall_cycles", 32'(stall_cnt), 32'd0);
         checkOutput("req_cycles", 32'(req_cnt), 32'd0);
         checkOutput("misalign", 32'(misalign), 32'd1);
         checkOutput("memreaddata", memreaddata, ERR_RDATA);
         checkOutput("buserr", 32'(buserr), 32'(model_buserr));
      end

      memread  = 1'b0;
      memwrite = 1'b0;
      bus_ack  = 1'b0;
   endtask

   initial begin
      logic [31:0] raddr;
      logic [1:0]  roff;
      int          kind;

      reset        = 1'b1;
      memread      = 1'b0;
      memwrite     = 1'b0;
      memaddr      = 32'h0;
      memwritedata = 32'h0;
      bus_ack      = 1'b0;
      bus_rdata    = 32'h0;

      // Reset values.
      #1;
      checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
      checkOutput("rst_bus_we", 32'(bus_we), 32'd0);
      checkOutput("rst_bus_addr", bus_addr, 32'h0);
      checkOutput("rst_bus_wdata", bus_wdata, 32'h0);
      checkOutput("rst_stall", 32'(stall), 32'd0);
      checkOutput("rst_misalign", 32'(misalign), 32'd0);
      checkOutput("rst_buserr", 32'(buserr), 32'd0);
      checkOutput("rst_memreaddata", memreaddata, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Directed cases: zero-wait load, store with three waits, misaligned
      // load, simultaneous read/write, and a load the bus never answers.
      applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h1234_5678);
      applyStimulus(1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 3, 32'hDEAD_BEEF);
      applyStimulus(1'b1, 1'b0, 32'h0000_0042, 32'h0, 0, 32'h5555_AAAA);
      applyStimulus(1'b1, 1'b1, 32'h0000_00C0, 32'h0BAD_F00D, 1, 32'h7777_7777);
      applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 99, 32'h9999_9999);
      applyStimulus(1'b1, 1'b0, 32'h0000_0104, 32'h0, 2, 32'hA5A5_0001);

      // Reset while a request is outstanding.
      @(negedge clk);
      memread = 1'b1;
      memaddr = 32'h0000_0200;
      @(negedge clk);
      #1;
      checkOutput("mid_req_bus_req", 32'(bus_req), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("rst_req_bus_req", 32'(bus_req), 32'd0);
      checkOutput("rst_req_stall", 32'(stall), 32'd0);
      checkOutput("rst_req_buserr", 32'(buserr), 32'd0);
      checkOutput("rst_req_memreaddata", memreaddata, 32'h0);
      memread      = 1'b0;
      model_buserr = 1'b0;
      model_rdata  = 32'h0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      bus_ack   = 1'b1;
      bus_rdata = 32'hFFFF_0000;
      #1;
      checkOutput("late_ack_bus_req", 32'(bus_req), 32'd0);
      checkOutput("late_ack_stall", 32'(stall), 32'd0);
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      checkOutput("late_ack_idle_req", 32'(bus_req), 32'd0);
      checkOutput("late_ack_memreaddata", memreaddata, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0204, 32'h0, 1, 32'h0F0F_1234);

      // Randomised traffic: loads, stores, both at once, occasional misaligned
      // addresses and latencies that run past the timeout.
      for (int n = 0; n < 60; n++) begin
         raddr = $urandom;
         roff  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         raddr = {raddr[31:2], roff};
         kind  = $urandom_range(0, 2);
         applyStimulus((kind != 1), (kind != 0), raddr, $urandom,
                       $urandom_range(0, TIMEOUT + 1), $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
